// File: rtl/button_debounce_pkg.sv
// Shared constants and width helpers for the pushbutton debouncer.
package button_debounce_pkg;

    localparam int BTN_DEFAULT_PRESCALE     = 50000;
    localparam int BTN_DEFAULT_STABLE_TICKS = 10;

    // Counter width for a value range 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One debounce channel: two-flop synchroniser, stability counter, level register.
// Optional one-cycle press pulse when BUTTON_DEBOUNCE_PRESS_PULSE_EN is defined.
//
// state     | meaning
// STABLE    | cnt_q == 0, synchronised input agrees with btn_level (or no tick seen yet)
// COUNTING  | cnt_q != 0, input has disagreed with btn_level for cnt_q consecutive ticks
module button_debounce_chan
    import button_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = BTN_DEFAULT_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    input  logic tick,
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
    output logic press_pulse,
`endif
    output logic btn_level
);

    localparam int             CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          s1;
    logic          s2;
    logic          pressed_s;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_d;

    assign pressed_s = ~s2;

    // Any agreement with the current level restarts the count, tick or not.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = btn_level;
        if (pressed_s == btn_level) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                level_d = ~btn_level;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            cnt_q     <= '0;
            btn_level <= 1'b0;
        end else begin
            s1        <= key_n;
            s2        <= s1;
            cnt_q     <= cnt_d;
            btn_level <= level_d;
        end
    end

`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
    logic level_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_prev  <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            level_prev  <= btn_level;
            press_pulse <= btn_level & ~level_prev;
        end
    end
`endif

endmodule

// File: rtl/button_debounce.sv
// Debounces raw active-low keys into clean active-high levels for the buttons PIO.
// Define BUTTON_DEBOUNCE_PRESS_PULSE_EN to add the press_pulse output.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int NUM_BTN      = 3,
    parameter int PRESCALE     = BTN_DEFAULT_PRESCALE,
    parameter int STABLE_TICKS = BTN_DEFAULT_STABLE_TICKS
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] key_n,
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
    output logic [NUM_BTN-1:0] press_pulse,
`endif
    output logic [NUM_BTN-1:0] btn_level
);

    localparam int            PW        = cnt_width(PRESCALE);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;
    logic          tick;

    // With PRESCALE=1 pcnt is pinned at 0 and tick stays high.
    assign tick = (pcnt == PCNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_n       (key_n[i]),
            .tick        (tick),
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
            .press_pulse (press_pulse[i]),
`endif
            .btn_level   (btn_level[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: stimulus queues expected level changes,
// a negedge monitor pops and checks them whenever a DUT output changes.
module tb_button_debounce;

    typedef struct {
        logic [2:0] lvl;
        int         lo;
        int         hi;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] key [3];
    logic       rst [3];
    logic [2:0] lvl [3];
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
    logic [2:0] pul [3];
`endif
    logic [2:0] h1 [3] = '{default: 3'b000};
    logic [2:0] h2 [3] = '{default: 3'b000};

    int   total = 0;
    int   bad   = 0;
    exp_t q [3][$];
    int   r_b;

    // dut_a: PRESCALE=1 STABLE_TICKS=4, dut_b: 4/3, dut_c: 1/8
    button_debounce #(.NUM_BTN(3), .PRESCALE(1), .STABLE_TICKS(4)) dut_a (
        .clk(clk), .reset_n(rst[0]), .key_n(key[0]),
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
        .press_pulse(pul[0]),
`endif
        .btn_level(lvl[0]));

    button_debounce #(.NUM_BTN(3), .PRESCALE(4), .STABLE_TICKS(3)) dut_b (
        .clk(clk), .reset_n(rst[1]), .key_n(key[1]),
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
        .press_pulse(pul[1]),
`endif
        .btn_level(lvl[1]));

    button_debounce #(.NUM_BTN(3), .PRESCALE(1), .STABLE_TICKS(8)) dut_c (
        .clk(clk), .reset_n(rst[2]), .key_n(key[2]),
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
        .press_pulse(pul[2]),
`endif
        .btn_level(lvl[2]));

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b required %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: change at cycle %0d required in [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input int k, input logic [2:0] v, input int lo, input int hi);
        exp_t e;
        e.lvl = v;
        e.lo  = lo;
        e.hi  = hi;
        q[k].push_back(e);
    endtask

    // Exact level-change cycle for dut_b: the synchronised mismatch is first
    // counted at edge c+3, ticks land on edges where (edge - r_b) % 4 == 0,
    // and the third tick flips the level.
    function automatic int dut_b_change(input int c);
        int t;
        t = c + 3;
        while (((t - r_b) % 4) != 0) t++;
        return t + 8;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (lvl[k] !== h1[k]) begin
                if (q[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_change dut%0d: got %b at cycle %0d, required no change",
                             k, lvl[k], cyc);
                end else begin
                    check($sformatf("level dut%0d", k), lvl[k], q[k][0].lvl);
                    check_rng($sformatf("latency dut%0d", k), cyc, q[k][0].lo, q[k][0].hi);
                    void'(q[k].pop_front());
                end
            end
`ifdef BUTTON_DEBOUNCE_PRESS_PULSE_EN
            if ((pul[k] | (h1[k] & ~h2[k])) != 3'b000)
                check($sformatf("press_pulse dut%0d", k), pul[k], h1[k] & ~h2[k]);
`endif
            h2[k] <= h1[k];
            h1[k] <= lvl[k];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1);
    end

    initial begin
        int c;
        key = '{3'b111, 3'b111, 3'b111};
        rst = '{1'b0, 1'b0, 1'b0};
        step(3);
        for (int k = 0; k < 3; k++) check($sformatf("reset level dut%0d", k), lvl[k], 3'b000);
        rst = '{1'b1, 1'b1, 1'b1};
        r_b = cyc;

        for (int i = 0; i < 100; i++) begin
            step(1);
            check("steady level", lvl[0], 3'b000);
        end

        // clean press and release on KEY0
        key[0][0] = 1'b0; c = cyc; expect_evt(0, 3'b001, c + 6, c + 6); step(20);
        key[0][0] = 1'b1; c = cyc; expect_evt(0, 3'b000, c + 6, c + 6); step(20);

        // bounce on KEY1: low 3, high 2, then low for good
        key[0][1] = 1'b0; step(3);
        key[0][1] = 1'b1; step(2);
        key[0][1] = 1'b0; c = cyc; expect_evt(0, 3'b010, c + 6, c + 6); step(20);
        key[0][1] = 1'b1; c = cyc; expect_evt(0, 3'b000, c + 6, c + 6); step(20);

        // simultaneous KEY0+KEY2, then only KEY0 released
        key[0] = 3'b010;  c = cyc; expect_evt(0, 3'b101, c + 6, c + 6); step(20);
        key[0][0] = 1'b1; c = cyc; expect_evt(0, 3'b100, c + 6, c + 6); step(20);
        key[0][2] = 1'b1; c = cyc; expect_evt(0, 3'b000, c + 6, c + 6); step(20);

        // prescaled: phase sweep over all four pcnt values, window [11,14]
        for (int p = 0; p < 4; p++) begin
            step(p);
            key[1][0] = 1'b0; c = cyc;
            expect_evt(1, 3'b001, dut_b_change(c), dut_b_change(c));
            step(30);
            key[1][0] = 1'b1; c = cyc;
            expect_evt(1, 3'b000, dut_b_change(c), dut_b_change(c));
            step(30);
        end

        // reset while KEY1 counter sits at 5
        key[2][1] = 1'b0; step(7);
        rst[2] = 1'b0;
        #1 check("mid reset level", lvl[2], 3'b000);
        step(3);
        check("mid reset level held", lvl[2], 3'b000);
        rst[2] = 1'b1; c = cyc; expect_evt(2, 3'b010, c + 10, c + 10); step(20);
        key[2][1] = 1'b1; c = cyc; expect_evt(2, 3'b000, c + 10, c + 10); step(20);

        step(5);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (q[k].size() != 0) begin
                bad++;
                $display("FAIL pending dut%0d: %0d expected changes never seen, required 0", k, q[k].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditioning stage directly upstream of the buttons PIO; its output drives the PIO's in_port.
- Takes raw, asynchronous, bouncing active-low DE2 KEY inputs.
- Synchronises each one to clk, debounces it, and presents a clean active-high "pressed" level.
- PIO edge capture then sees exactly one edge per physical press and one per release.

Parameters:
- NUM_BTN, 3, number of button channels.
- PRESCALE, 50000, clk cycles per debounce tick (1 ms at 50 MHz); legal range >= 1.
- STABLE_TICKS, 10, consecutive ticks an input must differ from the current state before that state flips; legal range >= 1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset.
- key_n  input  NUM_BTN  raw pushbuttons, active-low, asynchronous.
- btn_level  output  NUM_BTN  debounced state, 1 = pressed; feeds the PIO in_port.
- press_pulse  output  NUM_BTN  only present with the optional feature.

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - sync flops all 1 (released);
  - btn_level 0;
  - all channel counters 0;
  - prescale counter 0;
  - press_pulse 0.
- Synchroniser: two-flop chain per bit, key_n -> s1 -> s2. Define pressed_s = ~s2.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and wraps.
  - tick = (pcnt == PRESCALE-1), combinational.
  - PRESCALE=1 makes tick permanently 1.
  - pcnt width is clog2(PRESCALE), minimum 1.
- Per channel i, states STABLE / COUNTING (implicit: counter == 0 means STABLE):
  - pressed_s[i] == btn_level[i]: counter clears to 0 on the next clk, regardless of tick. A bounce mid-count restarts the count.
  - Mismatch and tick and counter < STABLE_TICKS-1: counter increments.
  - Mismatch and tick and counter == STABLE_TICKS-1: btn_level[i] toggles and the counter clears.
  - Mismatch and no tick: hold.
  - Counter width is clog2(STABLE_TICKS), minimum 1. The counter never exceeds STABLE_TICKS-1, so no wrap is possible.
- Latency from a clean raw transition to btn_level changing:
  - PRESCALE=1: exactly 2+STABLE_TICKS clk.
  - General case: between 3+(STABLE_TICKS-1)*PRESCALE and 2+STABLE_TICKS*PRESCALE clk, depending on tick phase.
- Channels are fully independent. Simultaneous transitions on several channels are each resolved on their own counter.
- Glitch rejection: any raw pulse shorter than (STABLE_TICKS-1)*PRESCALE clk never changes btn_level.
- Reset asserted mid-count: everything returns to reset values immediately (async). After release:
  - a button held throughout reports pressed after the normal latency;
  - no spurious release is output.
- btn_level is registered: no combinational path from key_n to any output.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_PRESS_PULSE_EN.
- Defined:
  - Adds port press_pulse[NUM_BTN-1:0].
  - Registered, high for exactly one clk in the cycle after btn_level[i] goes 0->1.
  - Never asserts on release.
  - Intended for polled software or direct LED toggles.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package button_debounce_pkg holds:
  - localparam functions for counter widths (clog2 with a minimum of 1);
  - default constants BTN_DEFAULT_PRESCALE=50000 and BTN_DEFAULT_STABLE_TICKS=10.
- Sub-module button_debounce_chan, one instance per channel. It contains the synchroniser, counter, level register and optional pulse register, and takes tick as an input.
- The prescaler stays in the top level and is shared by all channels.

Test Plan:
- Reset and steady state: PRESCALE=1, STABLE_TICKS=4, key_n=3'b111 held -> btn_level stays 3'b000 for 100 cycles; press_pulse stays 0.
- Clean press: PRESCALE=1, STABLE_TICKS=4; key_n[0] 1->0 just before edge k -> btn_level[0]=1 after edge k+6, not before; press_pulse[0] high for exactly one cycle after edge k+7.
- Bounce rejection: PRESCALE=1, STABLE_TICKS=4; key_n[1] toggled low for 3 cycles, high for 2, then low steadily -> a single 0->1 on btn_level[1], 6 cycles after the final low; no intermediate toggles.
- Prescaled timing: PRESCALE=4, STABLE_TICKS=3, sweep press phase over pcnt 0..3 -> latency always within [11,14] clk.
- Simultaneous and independent: press KEY0 and KEY2 on the same cycle, release KEY0 20 cycles later -> bits 0 and 2 rise together; only bit 0 falls; bit 1 is never disturbed.
- Reset mid-count: PRESCALE=1, STABLE_TICKS=8; KEY1 held low, reset_n pulsed at count 5 -> btn_level=0 during reset; btn_level[1]=1 exactly 10 cycles after reset release.
